exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 5-stage in-order pipeline, between ID and MEM.
- Latches the ID→EXE payload and computes the ALU result through the existing combinational `alu`.
- Runs an iterative 32-bit divider for div.w / mod.w / div.wu / mod.wu, and issues the data-SRAM request for ld.w / st.w.
- Produces the 103-bit EXE→MEM bus and a forwarding/load-use bus back to ID.

Parameters:
- DIV_ITER, 32, number of divider iterations (one quotient bit per cycle).

Ports:
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- exe_allowin  out  1  EXE can accept a new instruction this cycle.
- id_exe_valid  in  1  ID presents a valid instruction.
- id_exe_bus  in  183  {alu_op[11:0], div_en, div_op[1:0], alu_src1[31:0], alu_src2[31:0], rkd_value[31:0], mem_we, res_from_mem, gr_we, dest[4:0], pc[31:0], inst[31:0]}.
- exe_mem_valid  out  1  EXE→MEM payload valid.
- mem_allowin  in  1  MEM can accept.
- exe_mem_bus  out  103  {gr_we, res_from_mem, dest[4:0], pc[31:0], inst[31:0], result[31:0]}.
- exe_fwd_bus  out  39  {fwd_valid, is_load, dest[4:0], result[31:0]} to ID.
- data_sram_en  out  1  SRAM access enable.
- data_sram_we  out  4  byte write strobes.
- data_sram_addr  out  32  byte address, equal to the ALU result.
- data_sram_wdata  out  32  store data, equal to rkd_value.

Behaviour:
- Reset (async, active-high):
  - exe_valid=0.
  - Divider FSM=IDLE, iteration counter=0.
  - All outputs deasserted: exe_mem_valid=0, data_sram_en=0, data_sram_we=0, fwd_valid=0.
  - exe_allowin=1 while reset is high.
  - Payload register is not reset.
- Handshake:
  - exe_ready_go = ~div_en | (div_state==DONE).
  - exe_allowin = ~exe_valid | (exe_ready_go & mem_allowin).
  - exe_mem_valid = exe_valid & exe_ready_go.
  - exe_valid <= id_exe_valid on every edge where exe_allowin is high.
  - Payload latched only on id_exe_valid & exe_allowin.
- Non-divide instructions occupy EXE for 1 cycle when mem_allowin=1.
- result = divider result if div_en, otherwise ALU result.
- Divider FSM (restoring, operates on magnitudes):
  - IDLE → BUSY: on exe_valid & div_en. Latch |src1|, |src2|, and the result signs; counter cleared.
  - BUSY: one iteration per cycle. After DIV_ITER iterations → DONE.
  - DONE: holds the quotient/remainder with signs applied.
  - DONE → IDLE: on the edge where the instruction leaves (exe_valid & exe_ready_go & mem_allowin).
  - Latency: a div entering at edge E0 starts at E1 and is DONE at E33. Minimum EXE residency is 34 cycles.
- Divider operations and sign rules:
  - div_op: 00=div.w, 01=mod.w, 10=div.wu, 11=mod.wu.
  - Signed quotient sign = sign(src1) XOR sign(src2).
  - Signed remainder sign = sign(src1).
- Divider boundary conditions:
  - Divide by zero: quotient=0xFFFFFFFF, remainder=src1, for both signed and unsigned.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0.
  - A stall in DONE (mem_allowin=0) holds the result stable.
  - Back-to-back divides: the second is latched on the leaving edge; its FSM starts from IDLE on the next cycle.
  - Reset during BUSY aborts the operation and returns the FSM to IDLE.
- Data SRAM:
  - data_sram_en = exe_valid & exe_ready_go & mem_allowin & (res_from_mem | mem_we). The request is therefore issued exactly once, on the leaving cycle.
  - data_sram_we = {4{mem_we & data_sram_en}}. Word access only.
- Forwarding:
  - fwd_valid = exe_valid & gr_we & exe_ready_go & (dest!=0).
  - is_load = exe_valid & res_from_mem.
  - ID uses is_load for the load-use stall and stalls on a divide writer while fwd_valid=0.

Decomposition:
- Shared package holds:
  - bus widths: ID_EXE_BUS_W=183, EXE_MEM_BUS_W=103, EXE_FWD_BUS_W=39;
  - div_op encodings and divider FSM state constants (IDLE/BUSY/DONE).
- One sub-module: div_unit (start, signed, operands → done, quotient, remainder; owns the FSM and counter).
- The ALU is the existing `alu` instance.

Test Plan:
- add.w with src1=5, src2=7 and mem_allowin=1 → exe_mem_valid the cycle after acceptance; result=12; fwd_valid=1 with dest.
- div.w with src1=-7 (0xFFFFFFF9), src2=2 → exe_ready_go low for 33 cycles; result=0xFFFFFFFD. The mod.w variant gives 0xFFFFFFFF.
- div.wu with src1=0x12345678, src2=0 → quotient 0xFFFFFFFF. mod.wu gives 0x12345678. Also div.w 0x80000000/0xFFFFFFFF → 0x80000000.
- st.w with addr 0x1C008000, rkd=0xDEADBEEF and mem_allowin=0 for 3 cycles → data_sram_en stays 0 while stalled, then pulses once with we=4'hF and the given addr/wdata.
- ld.w → is_load=1 and fwd_valid=1; data_sram_en=1 and we=0 on the leaving cycle.
- Reset asserted at cycle 10 of a divide → exe_valid=0 immediately; the next divide completes with the correct result after a full 34 cycles.

Source files
------------

// File: rtl/exe_stage_pkg.sv
// Shared widths, payload layouts and divider encodings for the execute stage.
package exe_stage_pkg;

  localparam int ID_EXE_BUS_W  = 183;
  localparam int EXE_MEM_BUS_W = 103;
  localparam int EXE_FWD_BUS_W = 39;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_MOD  = 2'b01;
  localparam logic [1:0] DIV_OP_DIVU = 2'b10;
  localparam logic [1:0] DIV_OP_MODU = 2'b11;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic [11:0] alu_op;
    logic        div_en;
    logic [1:0]  div_op;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [31:0] rkd_value;
    logic        mem_we;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] inst;
  } id_exe_t;

  typedef struct packed {
    logic        gr_we;
    logic        res_from_mem;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] result;
  } exe_mem_t;

  typedef struct packed {
    logic        fwd_valid;
    logic        is_load;
    logic [4:0]  dest;
    logic [31:0] result;
  } exe_fwd_t;

  // Magnitude of a value that is only treated as two's complement when sgn is set.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn & v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU; alu_op is one-hot:
// add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui (passes src2).
module alu (
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);

  logic [31:0] sum, diff;
  logic        slt, sltu;
  logic [4:0]  sh;

  assign sum  = alu_src1 + alu_src2;
  assign diff = alu_src1 - alu_src2;
  assign slt  = $signed(alu_src1) < $signed(alu_src2);
  assign sltu = alu_src1 < alu_src2;
  assign sh   = alu_src2[4:0];

  always_comb begin
    alu_result = '0;
    unique case (1'b1)
      alu_op[0]:  alu_result = sum;
      alu_op[1]:  alu_result = diff;
      alu_op[2]:  alu_result = {31'd0, slt};
      alu_op[3]:  alu_result = {31'd0, sltu};
      alu_op[4]:  alu_result = alu_src1 & alu_src2;
      alu_op[5]:  alu_result = ~(alu_src1 | alu_src2);
      alu_op[6]:  alu_result = alu_src1 | alu_src2;
      alu_op[7]:  alu_result = alu_src1 ^ alu_src2;
      alu_op[8]:  alu_result = alu_src1 << sh;
      alu_op[9]:  alu_result = alu_src1 >> sh;
      alu_op[10]: alu_result = $unsigned($signed(alu_src1) >>> sh);
      alu_op[11]: alu_result = alu_src2;
      default:    alu_result = '0;
    endcase
  end

endmodule

// File: rtl/exe_stage_div_unit.sv
// Iterative restoring divider on operand magnitudes, one quotient bit per cycle.
module div_unit
  import exe_stage_pkg::*;
#(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic        clear_i,
  output logic        done_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  localparam int CW = $clog2(DIV_ITER + 1);

  div_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic        q_neg_q, q_neg_d, r_neg_q, r_neg_d;

  logic [32:0] trial;
  logic [33:0] sub;
  logic        ge;

  // quo_q starts as the dividend and is shifted out as quotient bits shift in.
  assign trial = {rem_q, quo_q[31]};
  assign sub   = {1'b0, trial} - {2'b00, dvs_q};
  assign ge    = ~sub[33];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    unique case (state_q)
      DIV_IDLE: if (start_i) begin
        state_d = DIV_BUSY;
        cnt_d   = '0;
        rem_d   = '0;
        quo_d   = mag32(src1_i, signed_i);
        dvs_d   = mag32(src2_i, signed_i);
        // Divide-by-zero keeps the all-ones quotient unsigned-looking.
        q_neg_d = signed_i & (src1_i[31] ^ src2_i[31]) & (src2_i != '0);
        r_neg_d = signed_i & src1_i[31];
      end
      DIV_BUSY: begin
        rem_d = ge ? sub[31:0] : trial[31:0];
        quo_d = {quo_q[30:0], ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DIV_ITER - 1)) state_d = DIV_DONE;
      end
      DIV_DONE: if (clear_i) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

  assign done_o = (state_q == DIV_DONE);
  assign quot_o = q_neg_q ? (~quo_q + 32'd1) : quo_q;
  assign rem_o  = r_neg_q ? (~rem_q + 32'd1) : rem_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: payload latch, ALU/divider result, data SRAM request and ID forwarding.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int DIV_ITER = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     exe_allowin,
  input  logic                     id_exe_valid,
  input  logic [ID_EXE_BUS_W-1:0]  id_exe_bus,
  output logic                     exe_mem_valid,
  input  logic                     mem_allowin,
  output logic [EXE_MEM_BUS_W-1:0] exe_mem_bus,
  output logic [EXE_FWD_BUS_W-1:0] exe_fwd_bus,
  output logic                     data_sram_en,
  output logic [3:0]               data_sram_we,
  output logic [31:0]              data_sram_addr,
  output logic [31:0]              data_sram_wdata
);

  logic        exe_valid_q;
  id_exe_t     pl_q;
  logic        exe_ready_go, leave;
  logic        div_done;
  logic [31:0] div_quot, div_rem, alu_result, result;
  exe_mem_t    mem_out;
  exe_fwd_t    fwd_out;

  assign exe_ready_go  = ~pl_q.div_en | div_done;
  assign exe_allowin   = ~exe_valid_q | (exe_ready_go & mem_allowin);
  assign exe_mem_valid = exe_valid_q & exe_ready_go;
  assign leave         = exe_valid_q & exe_ready_go & mem_allowin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            exe_valid_q <= 1'b0;
    else if (exe_allowin) exe_valid_q <= id_exe_valid;
  end

  // Payload is qualified by exe_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (id_exe_valid & exe_allowin) pl_q <= id_exe_t'(id_exe_bus);
  end

  alu u_alu (
    .alu_op     (pl_q.alu_op),
    .alu_src1   (pl_q.alu_src1),
    .alu_src2   (pl_q.alu_src2),
    .alu_result (alu_result)
  );

  div_unit #(.DIV_ITER(DIV_ITER)) u_div (
    .clk      (clk),
    .rst      (reset),
    .start_i  (exe_valid_q & pl_q.div_en),
    .signed_i (pl_q.div_op inside {DIV_OP_DIV, DIV_OP_MOD}),
    .src1_i   (pl_q.alu_src1),
    .src2_i   (pl_q.alu_src2),
    .clear_i  (leave),
    .done_o   (div_done),
    .quot_o   (div_quot),
    .rem_o    (div_rem)
  );

  always_comb begin
    result = alu_result;
    if (pl_q.div_en)
      result = (pl_q.div_op inside {DIV_OP_MOD, DIV_OP_MODU}) ? div_rem : div_quot;
  end

  assign data_sram_en    = leave & (pl_q.res_from_mem | pl_q.mem_we);
  assign data_sram_we    = {4{pl_q.mem_we & data_sram_en}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = pl_q.rkd_value;

  always_comb begin
    mem_out.gr_we        = pl_q.gr_we;
    mem_out.res_from_mem = pl_q.res_from_mem;
    mem_out.dest         = pl_q.dest;
    mem_out.pc           = pl_q.pc;
    mem_out.inst         = pl_q.inst;
    mem_out.result       = result;
    fwd_out.fwd_valid    = exe_valid_q & pl_q.gr_we & exe_ready_go & (pl_q.dest != 5'd0);
    fwd_out.is_load      = exe_valid_q & pl_q.res_from_mem;
    fwd_out.dest         = pl_q.dest;
    fwd_out.result       = result;
  end

  assign exe_mem_bus = mem_out;
  assign exe_fwd_bus = fwd_out;

endmodule

// File: tb/tb_exe_stage.sv
// Randomized and directed bench for exe_stage against a behavioural reference.
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         exe_allowin;
  logic         id_exe_valid;
  logic [182:0] id_exe_bus;
  logic         exe_mem_valid;
  logic         mem_allowin;
  logic [102:0] exe_mem_bus;
  logic [38:0]  exe_fwd_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_stage #(.DIV_ITER(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .exe_allowin     (exe_allowin),
    .id_exe_valid    (id_exe_valid),
    .id_exe_bus      (id_exe_bus),
    .exe_mem_valid   (exe_mem_valid),
    .mem_allowin     (mem_allowin),
    .exe_mem_bus     (exe_mem_bus),
    .exe_fwd_bus     (exe_fwd_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  function automatic logic [182:0] mk(input logic [11:0] op, input logic den, input logic [1:0] dop,
                                      input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] rkd,
                                      input logic mwe, input logic rfm, input logic gwe, input logic [4:0] dst,
                                      input logic [31:0] pc, input logic [31:0] inst);
    return {op, den, dop, s1, s2, rkd, mwe, rfm, gwe, dst, pc, inst};
  endfunction

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3: return (a < b) ? 32'd1 : 32'd0;
      4: return a & b;
      5: return ~(a | b);
      6: return a | b;
      7: return a ^ b;
      8: return a << b[4:0];
      9: return a >> b[4:0];
      10: return $unsigned($signed(a) >>> b[4:0]);
      default: return b;
    endcase
  endfunction

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[1]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[0] ? r : q;
  endfunction

  task automatic send(input logic [182:0] b);
    int n = 0;
    id_exe_bus   = b;
    id_exe_valid = 1'b1;
    while (!exe_allowin && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exe_allowin !== 1'b1) begin
      errors++;
      $display("FAIL send_accept got allowin=%b required 1", exe_allowin);
    end
    @(posedge clk); #1;
    id_exe_valid = 1'b0;
  endtask

  task automatic wait_mv(output int n);
    n = 0;
    while (!exe_mem_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; id_exe_valid = 1'b0; id_exe_bus = '0; mem_allowin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({exe_allowin, exe_mem_valid, data_sram_en, data_sram_we, exe_fwd_bus[38]} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_state got allowin=%b mv=%b en=%b we=%h fwd=%b required 1 0 0 0 0",
               exe_allowin, exe_mem_valid, data_sram_en, data_sram_we, exe_fwd_bus[38]);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu;
    logic [31:0] a, b, exp;
    logic [4:0]  dst;
    int op;
    for (int i = 0; i < 13; i++) begin
      if (i == 0) begin op = 0; a = 32'd5; b = 32'd7; dst = 5'd3; end
      else if (i == 1) begin op = 0; a = 32'd9; b = 32'd1; dst = 5'd0; end
      else begin
        op = $urandom_range(0, 11); a = $urandom; b = $urandom; dst = 5'($urandom_range(0, 31));
      end
      exp = ref_alu(op, a, b);
      send(mk(12'(1 << op), 1'b0, 2'b00, a, b, 32'd0, 1'b0, 1'b0, 1'b1, dst, 32'h1C00_0000 + 32'(i * 4), a ^ 32'h55));
      checks++;
      if (exe_mem_valid !== 1'b1 || exe_mem_bus[31:0] !== exp || exe_mem_bus[95:64] !== 32'h1C00_0000 + 32'(i * 4)) begin
        errors++;
        $display("FAIL alu_result op=%0d got mv=%b res=%h pc=%h required 1 %h %h",
                 op, exe_mem_valid, exe_mem_bus[31:0], exe_mem_bus[95:64], exp, 32'h1C00_0000 + 32'(i * 4));
      end
      checks++;
      if (exe_fwd_bus !== {(dst != 5'd0), 1'b0, dst, exp}) begin
        errors++;
        $display("FAIL alu_fwd got %h required %h", exe_fwd_bus, {(dst != 5'd0), 1'b0, dst, exp});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div;
    logic [1:0]  ops [12] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b11};
    logic [31:0] as  [12] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h1234_5678, 32'h1234_5678, 32'h8000_0000,
                              32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 0, 0, 0, 0};
    logic [31:0] bs  [12] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 0, 0, 0, 0};
    logic [31:0] exp;
    int n;
    for (int i = 8; i < 12; i++) begin
      as[i] = $urandom;
      bs[i] = $urandom >> $urandom_range(0, 28);
    end
    for (int i = 0; i < 16; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      if (i < 12) begin op = ops[i]; a = as[i]; b = bs[i]; end
      else begin op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      exp = ref_div(op, a, b);
      send(mk(12'd0, 1'b1, op, a, b, 32'd0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h1C00_1000, 32'd0));
      wait_mv(n);
      checks++;
      if (n != 33) begin
        errors++;
        $display("FAIL div_latency op=%0d got %0d stall cycles required 33", op, n);
      end
      checks++;
      if (exe_mem_bus[31:0] !== exp || exe_fwd_bus[38] !== 1'b1) begin
        errors++;
        $display("FAIL div_result op=%0d a=%h b=%h got %h fwd=%b required %h 1",
                 op, a, b, exe_mem_bus[31:0], exe_fwd_bus[38], exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_stall;
    int n;
    send(mk(12'd0, 1'b1, 2'b00, 32'd100, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0, 1'b1, 5'd7, 32'd0, 32'd0));
    mem_allowin = 1'b0;
    wait_mv(n);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (exe_mem_valid !== 1'b1 || exe_allowin !== 1'b0 || exe_mem_bus[31:0] !== 32'hFFFF_FFF2) begin
        errors++;
        $display("FAIL div_stall_hold cycle=%0d got mv=%b allowin=%b res=%h required 1 0 fffffff2",
                 k, exe_mem_valid, exe_allowin, exe_mem_bus[31:0]);
      end
      @(posedge clk); #1;
    end
    mem_allowin = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (exe_mem_valid !== 1'b0 || exe_allowin !== 1'b1) begin
      errors++;
      $display("FAIL div_stall_leave got mv=%b allowin=%b required 0 1", exe_mem_valid, exe_allowin);
    end
  endtask

  task automatic test_store;
    mem_allowin = 1'b0;
    send(mk(12'h001, 1'b0, 2'b00, 32'h1C00_8000, 32'd0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0));
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (data_sram_en !== 1'b0 || exe_mem_valid !== 1'b1) begin
        errors++;
        $display("FAIL store_stalled cycle=%0d got en=%b mv=%b required 0 1", k, data_sram_en, exe_mem_valid);
      end
      if (k < 2) begin @(posedge clk); #1; end
    end
    mem_allowin = 1'b1;
    #1;
    checks++;
    if ({data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata} !== {1'b1, 4'hF, 32'h1C00_8000, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL store_issue got en=%b we=%h addr=%h wdata=%h required 1 f 1c008000 deadbeef",
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata);
    end
    @(posedge clk); #1;
    checks++;
    if (data_sram_en !== 1'b0) begin
      errors++;
      $display("FAIL store_once got en=%b required 0", data_sram_en);
    end
  endtask

  task automatic test_load;
    send(mk(12'h001, 1'b0, 2'b00, 32'h1C00_0100, 32'd4, 32'd0, 1'b0, 1'b1, 1'b1, 5'd6, 32'd0, 32'd0));
    checks++;
    if ({exe_fwd_bus[38:37], data_sram_en, data_sram_we, data_sram_addr} !== {2'b11, 1'b1, 4'h0, 32'h1C00_0104}) begin
      errors++;
      $display("FAIL load_issue got fwd=%b ld=%b en=%b we=%h addr=%h required 1 1 1 0 1c000104",
               exe_fwd_bus[38], exe_fwd_bus[37], data_sram_en, data_sram_we, data_sram_addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_div;
    int n;
    send(mk(12'd0, 1'b1, 2'b00, 32'd1000, 32'd3, 32'd0, 1'b0, 1'b0, 1'b1, 5'd8, 32'd0, 32'd0));
    repeat (9) begin @(posedge clk); #1; end
    checks++;
    if (exe_allowin !== 1'b0) begin
      errors++;
      $display("FAIL mid_div_busy got allowin=%b required 0", exe_allowin);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (exe_allowin !== 1'b1 || exe_mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_div_reset got allowin=%b mv=%b required 1 0", exe_allowin, exe_mem_valid);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if (exe_allowin !== 1'b1) begin
      errors++;
      $display("FAIL after_reset got allowin=%b required 1", exe_allowin);
    end
    send(mk(12'd0, 1'b1, 2'b10, 32'hFFFF_FFF0, 32'd3, 32'd0, 1'b0, 1'b0, 1'b1, 5'd8, 32'd0, 32'd0));
    wait_mv(n);
    checks++;
    if (n != 33 || exe_mem_bus[31:0] !== 32'h5555_5550) begin
      errors++;
      $display("FAIL div_after_reset got lat=%0d res=%h required 33 55555550", n, exe_mem_bus[31:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int n;
    send(mk(12'd0, 1'b1, 2'b00, 32'hFFFF_FF9C, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1, 5'd9, 32'd0, 32'd0));
    id_exe_bus   = mk(12'd0, 1'b1, 2'b01, 32'hFFFF_FF9C, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1, 5'd10, 32'd0, 32'd0);
    id_exe_valid = 1'b1;
    wait_mv(n);
    checks++;
    if (n != 33 || exe_mem_bus[31:0] !== 32'hFFFF_FFF2 || exe_allowin !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first got lat=%0d res=%h allowin=%b required 33 fffffff2 1", n, exe_mem_bus[31:0], exe_allowin);
    end
    @(posedge clk); #1;
    id_exe_valid = 1'b0;
    wait_mv(n);
    checks++;
    if (n != 33 || exe_mem_bus[31:0] !== 32'hFFFF_FFFE || exe_mem_bus[100:96] !== 5'd10) begin
      errors++;
      $display("FAIL b2b_second got lat=%0d res=%h dest=%0d required 33 fffffffe 10",
               n, exe_mem_bus[31:0], exe_mem_bus[100:96]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_alu;
    test_div;
    test_div_stall;
    test_store;
    test_load;
    test_reset_mid_div;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

endmodule
